// File: rtl/serial_seq_gen.sv
// Serial pattern transmitter: captures a pattern/len on start and shifts it out MSB-first.
// Optional macro PATTERN_REPEAT_EN adds a 'rep' port that resends the pattern rep+1 times.
module serial_seq_gen #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  output logic               ready,
  output logic               data_out,
  output logic               valid,
  output logic               done
`ifdef PATTERN_REPEAT_EN
  ,
  input  logic [3:0]         rep
`endif
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] ONE_L     = LEN_W'(1);

  state_t             state;
  logic [MAX_LEN-1:0] pat_q;
  logic [LEN_W-1:0]   cnt;
  logic               len_ok;
  logic               accept;
  logic               first_bit;
  logic               next_bit;

`ifdef PATTERN_REPEAT_EN
  logic [LEN_W-1:0]   len_q;
  logic [3:0]         rep_left;
  logic               restart_bit;
`endif

  // Mask-based bit select keeps the index width independent of MAX_LEN.
  function automatic logic bit_at(input logic [MAX_LEN-1:0] v,
                                  input logic [LEN_W-1:0]   idx);
    return |(v & (MAX_LEN'(1) << idx));
  endfunction

  always_comb begin
    len_ok    = (len != '0) && (len <= MAX_LEN_L);
    accept    = (state == IDLE) && start && len_ok;
    first_bit = bit_at(pattern, len - ONE_L);
    next_bit  = bit_at(pat_q, cnt - ONE_L);
  end

`ifdef PATTERN_REPEAT_EN
  always_comb begin
    restart_bit = bit_at(pat_q, len_q - ONE_L);
  end
`endif

  // Single FSM: counter reaching zero at an edge ends a pass; outputs are registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      pat_q    <= '0;
      cnt      <= '0;
      ready    <= 1'b1;
      data_out <= 1'b0;
      valid    <= 1'b0;
      done     <= 1'b0;
`ifdef PATTERN_REPEAT_EN
      len_q    <= '0;
      rep_left <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          ready    <= 1'b1;
          valid    <= 1'b0;
          data_out <= 1'b0;
          if (accept) begin
            state    <= SHIFT;
            pat_q    <= pattern;
            cnt      <= len - ONE_L;
            ready    <= 1'b0;
            valid    <= 1'b1;
            data_out <= first_bit;
`ifdef PATTERN_REPEAT_EN
            len_q    <= len;
            rep_left <= rep;
`endif
          end
        end

        SHIFT: begin
          if (cnt == '0) begin
`ifdef PATTERN_REPEAT_EN
            if (rep_left != '0) begin
              rep_left <= rep_left - 4'd1;
              cnt      <= len_q - ONE_L;
              data_out <= restart_bit;
              valid    <= 1'b1;
            end else begin
              state    <= IDLE;
              ready    <= 1'b1;
              valid    <= 1'b0;
              data_out <= 1'b0;
              done     <= 1'b1;
            end
`else
            state    <= IDLE;
            ready    <= 1'b1;
            valid    <= 1'b0;
            data_out <= 1'b0;
            done     <= 1'b1;
`endif
          end else begin
            cnt      <= cnt - ONE_L;
            data_out <= next_bit;
            valid    <= 1'b1;
          end
        end

        default: begin
          state    <= IDLE;
          ready    <= 1'b1;
          valid    <= 1'b0;
          data_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_seq_gen.sv
// Directed self-checking bench for serial_seq_gen (default build, PATTERN_REPEAT_EN undefined).
module tb_serial_seq_gen;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] pattern;
  logic [3:0] len;
  logic       ready;
  logic       data_out;
  logic       valid;
  logic       done;

  int vectors     = 0;
  int miscompares = 0;

  serial_seq_gen #(.MAX_LEN(8), .LEN_W(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .pattern  (pattern),
    .len      (len),
    .ready    (ready),
    .data_out (data_out),
    .valid    (valid),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_output(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic r, input logic v,
                           input logic d, input logic dn);
    check_output({tag, ".ready"},    ready,    r);
    check_output({tag, ".valid"},    valid,    v);
    check_output({tag, ".data_out"}, data_out, d);
    check_output({tag, ".done"},     done,     dn);
  endtask

  initial begin
    bit exp_d  [10] = '{1, 0, 0, 1, 0, 1, 0, 0, 1, 0};
    bit exp_v  [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    bit exp_dn [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    bit max_d  [8]  = '{1, 0, 0, 0, 0, 0, 0, 1};

    // Reset held two cycles, then idle with start low.
    reset = 1'b1; start = 1'b0; pattern = 8'h00; len = 4'd0;
    tick();
    check_all("rst0", 1, 0, 0, 0);
    tick();
    check_all("rst1", 1, 0, 0, 0);
    reset = 1'b0;
    tick();
    check_all("idle0", 1, 0, 0, 0);
    tick();
    check_all("idle1", 1, 0, 0, 0);

    // len=3, pattern 010, single-cycle start.
    pattern = 8'b0000_0010; len = 4'd3; start = 1'b1;
    tick();
    start = 1'b0;
    check_all("p3.b0", 0, 1, 0, 0);
    tick();
    check_all("p3.b1", 0, 1, 1, 0);
    tick();
    check_all("p3.b2", 0, 1, 0, 0);
    tick();
    check_all("p3.done", 1, 0, 0, 1);
    tick();
    check_all("p3.after", 1, 0, 0, 0);

    // start held high: 1001, idle cycle, 1001, idle cycle.
    pattern = 8'b0000_1001; len = 4'd4; start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 9) start = 1'b0;
      check_output($sformatf("cont%0d.data_out", i), data_out, exp_d[i]);
      check_output($sformatf("cont%0d.valid", i),    valid,    exp_v[i]);
      check_output($sformatf("cont%0d.done", i),     done,     exp_dn[i]);
      check_output($sformatf("cont%0d.ready", i),    ready,    ~exp_v[i]);
    end
    tick();
    check_all("cont.stop", 1, 0, 0, 0);

    // Illegal lengths are ignored.
    pattern = 8'hFF; len = 4'd0; start = 1'b1;
    tick();
    check_all("len0", 1, 0, 0, 0);
    len = 4'd9;
    tick();
    check_all("len9", 1, 0, 0, 0);
    start = 1'b0;
    tick();
    check_all("len9.after", 1, 0, 0, 0);

    // Busy start with changed inputs: original 1101 must complete unchanged.
    pattern = 8'b0000_1101; len = 4'd4; start = 1'b1;
    tick();
    check_all("busy.b0", 0, 1, 1, 0);
    pattern = 8'b0000_0000; len = 4'd2;
    tick();
    start = 1'b0;
    check_all("busy.b1", 0, 1, 1, 0);
    tick();
    check_all("busy.b2", 0, 1, 0, 0);
    tick();
    check_all("busy.b3", 0, 1, 1, 0);
    tick();
    check_all("busy.done", 1, 0, 0, 1);
    tick();
    check_all("busy.after", 1, 0, 0, 0);

    // len=1 boundary.
    pattern = 8'b0000_0001; len = 4'd1; start = 1'b1;
    tick();
    start = 1'b0;
    check_all("len1.b0", 0, 1, 1, 0);
    tick();
    check_all("len1.done", 1, 0, 0, 1);
    tick();
    check_all("len1.after", 1, 0, 0, 0);

    // len=MAX_LEN boundary.
    pattern = 8'b1000_0001; len = 4'd8; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i != 0) tick();
      check_all($sformatf("len8.b%0d", i), 0, 1, max_d[i], 0);
    end
    tick();
    check_all("len8.done", 1, 0, 0, 1);

    // Asynchronous reset during bit 2 of a len=4 transmission.
    pattern = 8'b0000_1010; len = 4'd4; start = 1'b1;
    tick();
    start = 1'b0;
    check_all("arst.b0", 0, 1, 1, 0);
    tick();
    check_all("arst.b1", 0, 1, 0, 0);
    #2 reset = 1'b1;
    #1 check_all("arst.now", 1, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    tick();
    check_all("arst.after0", 1, 0, 0, 0);
    tick();
    check_all("arst.after1", 1, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
